// File: rtl/ocp_slave_fsm.sv
// OCP basic-group slave that maps a window of OCP addresses onto a single-beat local memory port.
// Latency: accept/response one cycle after decode (errors) or one cycle after mem_ready/timeout (accesses).
// Backpressure: mem_ready stalls the access up to TIMEOUT cycles; MRespAccept holds read responses; EnableClk freezes everything.
//
// Ports:
//   Clk, reset (sync active-high), EnableClk (global clock enable)
//   MCmd/MAddr/MData/MRespAccept        : OCP request side from the master
//   SCmdAccept/SResp/SData              : OCP accept and response, all registered
//   mem_req/mem_we/mem_addr/mem_wdata   : local memory request, held stable until mem_ready
//   mem_ready/mem_rdata/mem_err         : local memory completion
//   err_cnt                             : saturating count of errored or dropped transactions
module ocp_slave_fsm #(
    parameter int                   ADDR_WDTH      = 64,
    parameter int                   DATA_WDTH      = 8,
    parameter int                   MEM_AW         = 16,
    parameter logic [ADDR_WDTH-1:0] ADDR_BASE      = '0,
    parameter int                   TIMEOUT        = 15,
    parameter bit                   RESP_ACCEPT_EN = 1'b1
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 EnableClk,
    input  logic [2:0]           MCmd,
    input  logic [ADDR_WDTH-1:0] MAddr,
    input  logic [DATA_WDTH-1:0] MData,
    input  logic                 MRespAccept,
    output logic                 SCmdAccept,
    output logic [1:0]           SResp,
    output logic [DATA_WDTH-1:0] SData,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [MEM_AW-1:0]    mem_addr,
    output logic [DATA_WDTH-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic [DATA_WDTH-1:0] mem_rdata,
    input  logic                 mem_err,
    output logic [7:0]           err_cnt
);

    localparam logic [2:0] CMD_IDLE = 3'd0;
    localparam logic [2:0] CMD_WR   = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_RDEX = 3'd3;
    localparam logic [2:0] CMD_RDL  = 3'd4;
    localparam logic [2:0] CMD_WRNP = 3'd5;
    localparam logic [2:0] CMD_WRC  = 3'd6;
    localparam logic [2:0] CMD_BCST = 3'd7;

    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    // Abort fires on the cycle the wait counter would reach TIMEOUT,
    // so mem_req is high for exactly TIMEOUT cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    // Window end computed one bit wider so a window touching the top of
    // the address space does not wrap.
    localparam logic [ADDR_WDTH:0] WIN_END =
        {1'b0, ADDR_BASE} + ((ADDR_WDTH+1)'(1) << MEM_AW);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_MEM = 2'd1,
        ST_RD_MEM = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [7:0]             tcnt, tcnt_nxt;
    logic                   acc_nxt;
    logic [1:0]             resp_nxt;
    logic [DATA_WDTH-1:0]   sdata_nxt;
    logic                   req_nxt;
    logic                   we_nxt;
    logic [MEM_AW-1:0]      addr_nxt;
    logic [DATA_WDTH-1:0]   wdata_nxt;
    logic                   err_inc;
    logic [7:0]             err_cnt_nxt;

    logic                   in_win;
    logic [MEM_AW-1:0]      offset;

    assign in_win = (MAddr >= ADDR_BASE) && ({1'b0, MAddr} < WIN_END);
    assign offset = MEM_AW'(MAddr - ADDR_BASE);

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        acc_nxt   = 1'b0;
        resp_nxt  = SResp;
        sdata_nxt = SData;
        req_nxt   = mem_req;
        we_nxt    = mem_we;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        err_inc   = 1'b0;

        case (state)
            ST_IDLE: begin
                // The master still presents the accepted command during
                // the accept cycle, so that cycle is never decoded.
                if (!SCmdAccept) begin
                    case (MCmd)
                        CMD_IDLE: ;
                        CMD_WR: begin
                            if (in_win) begin
                                addr_nxt  = offset;
                                wdata_nxt = MData;
                                req_nxt   = 1'b1;
                                we_nxt    = 1'b1;
                                tcnt_nxt  = '0;
                                state_nxt = ST_WR_MEM;
                            end else begin
                                acc_nxt = 1'b1;
                                err_inc = 1'b1;
                            end
                        end
                        CMD_RD: begin
                            if (in_win) begin
                                addr_nxt  = offset;
                                req_nxt   = 1'b1;
                                we_nxt    = 1'b0;
                                tcnt_nxt  = '0;
                                state_nxt = ST_RD_MEM;
                            end else begin
                                acc_nxt   = 1'b1;
                                resp_nxt  = RESP_ERR;
                                sdata_nxt = '0;
                                err_inc   = 1'b1;
                                state_nxt = ST_RESP;
                            end
                        end
                        CMD_RDEX, CMD_RDL: begin
                            acc_nxt   = 1'b1;
                            resp_nxt  = RESP_ERR;
                            sdata_nxt = '0;
                            err_inc   = 1'b1;
                            state_nxt = ST_RESP;
                        end
                        CMD_WRNP, CMD_WRC, CMD_BCST: begin
                            acc_nxt = 1'b1;
                            err_inc = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            ST_WR_MEM: begin
                if (mem_ready || tcnt == TO_LAST) begin
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    acc_nxt   = 1'b1;
                    err_inc   = !mem_ready || mem_err;
                    state_nxt = ST_IDLE;
                end else begin
                    tcnt_nxt = tcnt + 8'd1;
                end
            end

            ST_RD_MEM: begin
                if (mem_ready || tcnt == TO_LAST) begin
                    req_nxt   = 1'b0;
                    acc_nxt   = 1'b1;
                    state_nxt = ST_RESP;
                    if (mem_ready && !mem_err) begin
                        resp_nxt  = RESP_DVA;
                        sdata_nxt = mem_rdata;
                    end else begin
                        resp_nxt  = RESP_ERR;
                        sdata_nxt = '0;
                        err_inc   = 1'b1;
                    end
                end else begin
                    tcnt_nxt = tcnt + 8'd1;
                end
            end

            ST_RESP: begin
                if (!RESP_ACCEPT_EN || MRespAccept) begin
                    resp_nxt  = RESP_NULL;
                    sdata_nxt = '0;
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase

        err_cnt_nxt = (err_inc && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tcnt       <= '0;
            SCmdAccept <= 1'b0;
            SResp      <= RESP_NULL;
            SData      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            err_cnt    <= '0;
        end else if (EnableClk) begin
            state      <= state_nxt;
            tcnt       <= tcnt_nxt;
            SCmdAccept <= acc_nxt;
            SResp      <= resp_nxt;
            SData      <= sdata_nxt;
            mem_req    <= req_nxt;
            mem_we     <= we_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            err_cnt    <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ocp_slave_fsm.sv
// Directed bench for ocp_slave_fsm: writes, reads, window edges, timeout,
// reset mid-access, clock-enable freeze and err_cnt saturation.
module tb_ocp_slave_fsm;

    localparam logic [63:0] BASE = 64'h0000_0001_0000_0000;

    logic        Clk = 1'b0;
    logic        reset, EnableClk;
    logic [2:0]  MCmd;
    logic [63:0] MAddr;
    logic [7:0]  MData;
    logic        MRespAccept;
    logic        SCmdAccept;
    logic [1:0]  SResp;
    logic [7:0]  SData;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        mem_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    ocp_slave_fsm #(
        .ADDR_WDTH(64), .DATA_WDTH(8), .MEM_AW(16), .ADDR_BASE(BASE),
        .TIMEOUT(15), .RESP_ACCEPT_EN(1'b1)
    ) dut (
        .Clk(Clk), .reset(reset), .EnableClk(EnableClk),
        .MCmd(MCmd), .MAddr(MAddr), .MData(MData), .MRespAccept(MRespAccept),
        .SCmdAccept(SCmdAccept), .SResp(SResp), .SData(SData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .err_cnt(err_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int acc;
        int dbl;
        logic prev;

        reset = 1'b1; EnableClk = 1'b1; MCmd = 3'd0; MAddr = '0; MData = '0;
        MRespAccept = 1'b0; mem_ready = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        tick();
        reset = 1'b0;
        chk("rst_acc",   64'(SCmdAccept), 64'd0);
        chk("rst_resp",  64'(SResp),      64'd0);
        chk("rst_sdata", 64'(SData),      64'd0);
        chk("rst_req",   64'(mem_req),    64'd0);
        chk("rst_addr",  64'(mem_addr),   64'd0);
        chk("rst_err",   64'(err_cnt),    64'd0);

        // In-window write, mem_ready two cycles after mem_req rises
        MCmd = 3'd1; MAddr = BASE + 64'd5; MData = 8'hA5;
        tick();
        MCmd = 3'd0;
        chk("wr_req",   64'(mem_req),   64'd1);
        chk("wr_we",    64'(mem_we),    64'd1);
        chk("wr_addr",  64'(mem_addr),  64'd5);
        chk("wr_wdata", 64'(mem_wdata), 64'hA5);
        chk("wr_noacc", 64'(SCmdAccept), 64'd0);
        tick();
        chk("wr_hold_req",  64'(mem_req),  64'd1);
        chk("wr_hold_addr", 64'(mem_addr), 64'd5);
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("wr_done_req", 64'(mem_req),    64'd0);
        chk("wr_done_acc", 64'(SCmdAccept), 64'd1);
        chk("wr_noresp",   64'(SResp),      64'd0);
        tick();
        chk("wr_acc_pulse", 64'(SCmdAccept), 64'd0);
        chk("wr_err_cnt",   64'(err_cnt),    64'd0);

        // Read with immediate mem_ready, MRespAccept on the 4th response cycle
        MCmd = 3'd2; MAddr = BASE + 64'd5;
        tick();
        MCmd = 3'd0;
        chk("rd_req",  64'(mem_req),  64'd1);
        chk("rd_we",   64'(mem_we),   64'd0);
        chk("rd_addr", 64'(mem_addr), 64'd5);
        mem_ready = 1'b1; mem_rdata = 8'h3C;
        tick();
        mem_ready = 1'b0; mem_rdata = 8'h00;
        chk("rd_acc",   64'(SCmdAccept), 64'd1);
        chk("rd_req0",  64'(mem_req),    64'd0);
        chk("rd_resp1", 64'(SResp),      64'd1);
        chk("rd_data1", 64'(SData),      64'h3C);
        tick();
        chk("rd_acc_pulse", 64'(SCmdAccept), 64'd0);
        chk("rd_resp2", 64'(SResp), 64'd1);
        tick();
        chk("rd_resp3", 64'(SResp), 64'd1);
        tick();
        chk("rd_resp4", 64'(SResp), 64'd1);
        chk("rd_data4", 64'(SData), 64'h3C);
        MRespAccept = 1'b1;
        tick();
        MRespAccept = 1'b0;
        chk("rd_resp_null", 64'(SResp), 64'd0);
        chk("rd_data_zero", 64'(SData), 64'd0);

        // Read one past the window end, accepted on its first response cycle
        MCmd = 3'd2; MAddr = BASE + 64'h1_0000;
        tick();
        MCmd = 3'd0;
        chk("oob_rd_req",  64'(mem_req),    64'd0);
        chk("oob_rd_acc",  64'(SCmdAccept), 64'd1);
        chk("oob_rd_resp", 64'(SResp),      64'd3);
        chk("oob_rd_data", 64'(SData),      64'd0);
        chk("oob_rd_err",  64'(err_cnt),    64'd1);
        MRespAccept = 1'b1;
        tick();
        MRespAccept = 1'b0;
        chk("oob_rd_one_cycle", 64'(SResp), 64'd0);

        // WRC is dropped: accept pulse and error count only
        MCmd = 3'd6; MAddr = BASE;
        tick();
        MCmd = 3'd0;
        chk("wrc_acc",  64'(SCmdAccept), 64'd1);
        chk("wrc_req",  64'(mem_req),    64'd0);
        chk("wrc_resp", 64'(SResp),      64'd0);
        chk("wrc_err",  64'(err_cnt),    64'd2);
        tick();

        // Last in-window byte, backend reports an error
        MCmd = 3'd1; MAddr = BASE + 64'hFFFF; MData = 8'h11;
        tick();
        MCmd = 3'd0;
        chk("top_req",  64'(mem_req),  64'd1);
        chk("top_addr", 64'(mem_addr), 64'hFFFF);
        mem_ready = 1'b1; mem_err = 1'b1;
        tick();
        mem_ready = 1'b0; mem_err = 1'b0;
        chk("top_acc",  64'(SCmdAccept), 64'd1);
        chk("top_resp", 64'(SResp),      64'd0);
        chk("top_err",  64'(err_cnt),    64'd3);
        tick();

        // One below the window base
        MCmd = 3'd1; MAddr = BASE - 64'd1;
        tick();
        MCmd = 3'd0;
        chk("below_req", 64'(mem_req),    64'd0);
        chk("below_acc", 64'(SCmdAccept), 64'd1);
        chk("below_err", 64'(err_cnt),    64'd4);
        tick();

        // Timeout: mem_req must be high for exactly 15 cycles
        MCmd = 3'd2; MAddr = BASE + 64'd7;
        tick();
        MCmd = 3'd0;
        chk("to_req", 64'(mem_req), 64'd1);
        n = 1;
        while (mem_req && n < 40) begin
            tick();
            if (mem_req) n++;
        end
        chk("to_req_cycles", 64'(n), 64'd15);
        chk("to_acc",  64'(SCmdAccept), 64'd1);
        chk("to_resp", 64'(SResp),      64'd3);
        chk("to_err",  64'(err_cnt),    64'd5);
        mem_ready = 1'b1; mem_rdata = 8'hEE;
        tick();
        mem_ready = 1'b0;
        chk("late_rdy_resp", 64'(SResp),   64'd3);
        chk("late_rdy_data", 64'(SData),   64'd0);
        chk("late_rdy_err",  64'(err_cnt), 64'd5);
        MRespAccept = 1'b1;
        tick();
        MRespAccept = 1'b0;
        chk("to_resp_null", 64'(SResp), 64'd0);

        // Reset while a read waits on the backend
        MCmd = 3'd2; MAddr = BASE + 64'd9;
        tick();
        MCmd = 3'd0;
        chk("rr_req", 64'(mem_req), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_req0",  64'(mem_req), 64'd0);
        chk("rr_resp",  64'(SResp),   64'd0);
        chk("rr_err",   64'(err_cnt), 64'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("rr_quiet_acc", 64'(SCmdAccept), 64'd0);
        chk("rr_quiet_err", 64'(err_cnt),    64'd0);

        // EnableClk low freezes the response regardless of MRespAccept
        MCmd = 3'd2; MAddr = BASE + 64'd3;
        tick();
        MCmd = 3'd0;
        mem_ready = 1'b1; mem_rdata = 8'h5A;
        tick();
        mem_ready = 1'b0;
        chk("en_resp", 64'(SResp), 64'd1);
        EnableClk = 1'b0; MRespAccept = 1'b1;
        tick(); tick(); tick();
        chk("en_frz_resp", 64'(SResp),      64'd1);
        chk("en_frz_data", 64'(SData),      64'h5A);
        chk("en_frz_acc",  64'(SCmdAccept), 64'd1);
        EnableClk = 1'b1;
        tick();
        MRespAccept = 1'b0;
        chk("en_resp_null", 64'(SResp),      64'd0);
        chk("en_acc_low",   64'(SCmdAccept), 64'd0);

        // 300 dropped writes held back-to-back: counter saturates
        MCmd = 3'd1; MAddr = 64'd0;
        acc = 0; dbl = 0; prev = 1'b0; n = 0;
        while (acc < 300 && n < 1000) begin
            tick();
            n++;
            if (SCmdAccept) begin
                if (prev) dbl++;
                acc++;
                if (acc == 200) chk("sat_mid", 64'(err_cnt), 64'd200);
            end
            prev = SCmdAccept;
        end
        MCmd = 3'd0;
        tick();
        chk("sat_accepts", 64'(acc), 64'd300);
        chk("sat_no_back2back", 64'(dbl), 64'd0);
        chk("sat_err", 64'(err_cnt), 64'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ocp_slave_fsm.md
Name: ocp_slave_fsm

Overview:
- OCP 3.0 basic-group slave sitting directly downstream of the bridge's OCP master controller.
- Decodes MCmd/MAddr/MData from the bus and performs single-beat reads and writes on a local memory port with a ready handshake.
- Returns read data on SData/SResp and enforces an address window and a backend timeout.
- No bursts, threads or tags.

Parameters:
ADDR_WDTH, 64, OCP address width (MAddr)
DATA_WDTH, 8, OCP/memory data width
MEM_AW, 16, local memory address width; window size is 2**MEM_AW bytes
ADDR_BASE, 64'h0, first OCP address mapped to the local memory
TIMEOUT, 15, max cycles waiting for mem_ready before abort (1..255)
RESP_ACCEPT_EN, 1, 1 = hold response until MRespAccept; 0 = response lasts one cycle

Ports:
Clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
EnableClk  in  1  when 0, every register holds its value (reset still wins)
MCmd  in  3  OCP command: IDLE=0 WR=1 RD=2 RDEX=3 RDL=4 WRNP=5 WRC=6 BCST=7
MAddr  in  ADDR_WDTH  request address
MData  in  DATA_WDTH  write data
MRespAccept  in  1  master accepts the response
SCmdAccept  out  1  request accepted, registered single-cycle pulse
SResp  out  2  NULL=0 DVA=1 FAIL=2 ERR=3
SData  out  DATA_WDTH  read data
mem_req  out  1  local access request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  MEM_AW  MAddr - ADDR_BASE, truncated
mem_wdata  out  DATA_WDTH  write data
mem_ready  in  1  backend completes access (sampled while mem_req=1)
mem_rdata  in  DATA_WDTH  read data, valid with mem_ready
mem_err  in  1  backend error, valid with mem_ready
err_cnt  out  8  saturating count of error/dropped transactions

Behaviour:
- Reset values: SCmdAccept=0, SResp=NULL, SData=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err_cnt=0, state=IDLE, timeout counter=0.
- Reset takes effect on the edge it is sampled, regardless of EnableClk. A reset mid-access drops mem_req and any pending response; the aborted transaction does not increment err_cnt.
- All outputs are registered. With EnableClk=0 nothing advances.
- States: IDLE, WR_MEM, RD_MEM, RESP.
- IDLE, MCmd=WR, in window:
  - Latch mem_addr and mem_wdata.
  - mem_req=1, mem_we=1 from next cycle; go to WR_MEM.
- IDLE, MCmd=RD, in window:
  - Latch mem_addr; mem_req=1, mem_we=0; go to RD_MEM.
- In window means ADDR_BASE <= MAddr < ADDR_BASE + 2**MEM_AW, computed at full ADDR_WDTH with no wrap.
- IDLE, out-of-window RD, or MCmd=RDEX/RDL:
  - Next cycle: SCmdAccept=1 and SResp=ERR, SData=0; err_cnt++; go to RESP.
- IDLE, out-of-window WR, or MCmd=WRNP/WRC/BCST:
  - Next cycle: SCmdAccept=1 pulse, no memory access, err_cnt++; stay IDLE.
- WR_MEM/RD_MEM: hold mem_req and all mem_* outputs stable until mem_ready is sampled 1. The timeout counter increments each cycle without mem_ready.
- mem_ready=1 in WR_MEM:
  - Next cycle: mem_req=0, SCmdAccept=1 pulse; go to IDLE.
  - If mem_err=1, err_cnt++. No SResp is ever driven for writes.
- mem_ready=1 in RD_MEM:
  - Next cycle: mem_req=0, SCmdAccept=1, SData=mem_rdata, SResp=DVA (ERR and SData=0 if mem_err, err_cnt++); go to RESP.
- Timeout: counter reaching TIMEOUT without mem_ready has the same effect as mem_ready with mem_err=1. Late mem_ready after abort is ignored.
- Accept and response may coincide. SCmdAccept is always exactly one cycle, after which MCmd is ignored for at least one cycle.
- RESP, RESP_ACCEPT_EN=1: hold SResp/SData until MRespAccept is sampled 1, then next cycle SResp=NULL, SData=0, go IDLE. If MRespAccept is already 1 on the first RESP cycle, the response lasts one cycle.
- RESP, RESP_ACCEPT_EN=0: SResp lasts exactly one cycle.
- New commands are not decoded while in RESP. The first new command is decoded in the cycle after returning to IDLE.
- The timeout counter clears on entry to WR_MEM/RD_MEM.
- err_cnt saturates at 255 and does not wrap.

Test Plan:
- Write in window: MCmd=WR, MAddr=ADDR_BASE+5, MData=8'hA5, mem_ready 2 cycles after mem_req -> mem_addr=5, mem_wdata=A5, mem_we=1; SCmdAccept one-cycle pulse the cycle after mem_ready; SResp stays NULL.
- Read with accept: MCmd=RD, addr offset 5, mem_rdata=8'h3C with mem_ready on first mem_req cycle, MRespAccept delayed 3 cycles -> SCmdAccept pulse, SResp=DVA and SData=3C held 4 cycles, then NULL/0.
- Out-of-window: RD at ADDR_BASE+2**MEM_AW -> no mem_req, SResp=ERR, err_cnt=1; then WRC -> SCmdAccept pulse, err_cnt=2.
- Timeout: RD with mem_ready held 0 -> mem_req drops after exactly TIMEOUT=15 cycles, SResp=ERR; mem_ready pulsed later -> no effect.
- Reset mid-read: assert reset while in RD_MEM -> mem_req=0, SResp=NULL, err_cnt unchanged at 0 next cycle. EnableClk=0 during RESP -> SResp frozen regardless of MRespAccept.
- Saturation: 300 out-of-window writes -> err_cnt=255.
